// File: rtl/bias_ctrl_pkg.sv
// Shared types and constants for the EG1 bias/bandgap cell sequencer.
package bias_ctrl_pkg;

    localparam int unsigned TRIM_BIAS_W = 4;
    localparam int unsigned TRIM_CURV_W = 5;
    localparam int unsigned TRIM_VBG_W  = 5;

    // Consecutive invalid READY cycles that count as loss of valid.
    localparam int unsigned WDOG_LEN = 4;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_STARTUP    = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_WAIT_VALID = 3'd3,
        ST_READY      = 3'd4,
        ST_FAULT      = 3'd5
    } bias_state_e;

    typedef struct packed {
        logic [TRIM_BIAS_W-1:0] bias;
        logic [TRIM_CURV_W-1:0] curv;
        logic [TRIM_VBG_W-1:0]  vbg;
    } trim_t;

    function automatic logic cell_enabled(bias_state_e s);
        return (s == ST_STARTUP) || (s == ST_SETTLE) ||
               (s == ST_WAIT_VALID) || (s == ST_READY);
    endfunction

endpackage

// File: rtl/bias_ctrl_sync.sv
// Two-flop synchronizer with a configurable reset value.
module bias_ctrl_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bias_ctrl.sv
// Power-up sequencer for the EG1 bias/bandgap cell: enable, startup pulse, trims, VBIAS.
// Optional valid watchdog in READY is enabled by defining BIAS_CTRL_VALID_WDOG_EN.
module bias_ctrl
    import bias_ctrl_pkg::*;
#(
    parameter int unsigned STARTUP_CYCLES = 64,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W          = 17,
    parameter logic [TRIM_BIAS_W-1:0] TRIM_BIAS_DEF = 4'h8,
    parameter logic [TRIM_CURV_W-1:0] TRIM_CURV_DEF = 5'h10,
    parameter logic [TRIM_VBG_W-1:0]  TRIM_VBG_DEF  = 5'h10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   vbias_req_i,
    input  logic                   trim_load_i,
    input  logic [TRIM_BIAS_W-1:0] trim_bias_i,
    input  logic [TRIM_CURV_W-1:0] trim_curv_i,
    input  logic [TRIM_VBG_W-1:0]  trim_vbg_i,
    input  logic                   bg_valid_n_i,
    output logic                   en_o,
    output logic                   bg_startup_o,
    output logic                   en_vbias_o,
    output logic [TRIM_BIAS_W-1:0] trim_bias_o,
    output logic [TRIM_CURV_W-1:0] trim_curv_o,
    output logic [TRIM_VBG_W-1:0]  trim_vbg_o,
    output logic                   ready_o,
    output logic                   fault_o,
    output logic [2:0]             state_o
);

    localparam logic [CNT_W-1:0] START_LOAD   = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam trim_t TRIM_DEF = '{bias: TRIM_BIAS_DEF, curv: TRIM_CURV_DEF, vbg: TRIM_VBG_DEF};

    bias_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    trim_t            trim_q, trim_d;
    trim_t            shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             en_q, en_d;
    logic             startup_q, startup_d;
    logic             vbias_q, vbias_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
`ifdef BIAS_CTRL_VALID_WDOG_EN
    logic [2:0]       wdog_q, wdog_d;
`endif

    trim_t trim_in;
    logic  valid_n_s;
    logic  valid_s;

    assign trim_in = '{bias: trim_bias_i, curv: trim_curv_i, vbg: trim_vbg_i};

    bias_ctrl_sync #(
        .RST_VAL (1'b1)
    ) u_valid_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (bg_valid_n_i),
        .q_o   (valid_n_s)
    );

    assign valid_s = !valid_n_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            trim_q    <= TRIM_DEF;
            shadow_q  <= TRIM_DEF;
            pend_q    <= 1'b0;
            en_q      <= 1'b0;
            startup_q <= 1'b0;
            vbias_q   <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
`ifdef BIAS_CTRL_VALID_WDOG_EN
            wdog_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            trim_q    <= trim_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            en_q      <= en_d;
            startup_q <= startup_d;
            vbias_q   <= vbias_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
`ifdef BIAS_CTRL_VALID_WDOG_EN
            wdog_q    <= wdog_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        trim_d   = trim_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
`ifdef BIAS_CTRL_VALID_WDOG_EN
        wdog_d   = '0;
`endif

        if (!enable_i) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            pend_d  = 1'b0;
            if (trim_load_i) begin
                trim_d = trim_in;
            end
        end else begin
            // Loads during bring-up are deferred so the live trims stay stable.
            if (trim_load_i && (state_q == ST_STARTUP || state_q == ST_SETTLE ||
                                state_q == ST_WAIT_VALID)) begin
                shadow_d = trim_in;
                pend_d   = 1'b1;
            end

            case (state_q)
                ST_OFF: begin
                    if (trim_load_i) begin
                        trim_d = trim_in;
                    end
                    state_d = ST_STARTUP;
                    cnt_d   = START_LOAD;
                end
                ST_STARTUP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_WAIT_VALID;
                        cnt_d   = TIMEOUT_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_WAIT_VALID: begin
                    if (valid_s) begin
                        // A pending trim is applied instead of entering READY; re-settle first.
                        if (pend_d) begin
                            trim_d  = shadow_d;
                            pend_d  = 1'b0;
                            state_d = ST_SETTLE;
                            cnt_d   = SETTLE_LOAD;
                        end else begin
                            state_d = ST_READY;
                            cnt_d   = '0;
                        end
                    end else if (cnt_q == '0) begin
                        state_d = ST_FAULT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_READY: begin
                    if (trim_load_i) begin
                        trim_d  = trim_in;
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
`ifdef BIAS_CTRL_VALID_WDOG_EN
                    else if (!valid_s) begin
                        if (wdog_q == 3'(WDOG_LEN - 1)) begin
                            state_d = ST_FAULT;
                        end else begin
                            wdog_d = wdog_q + 3'd1;
                        end
                    end
`endif
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end

        en_d      = cell_enabled(state_d);
        startup_d = (state_d == ST_STARTUP);
        ready_d   = (state_d == ST_READY);
        fault_d   = (state_d == ST_FAULT);
        vbias_d   = vbias_req_i && (state_q == ST_READY) && (state_d == ST_READY);
    end

    assign en_o         = en_q;
    assign bg_startup_o = startup_q;
    assign en_vbias_o   = vbias_q;
    assign ready_o      = ready_q;
    assign fault_o      = fault_q;
    assign trim_bias_o  = trim_q.bias;
    assign trim_curv_o  = trim_q.curv;
    assign trim_vbg_o   = trim_q.vbg;
    assign state_o      = state_q;

endmodule
